// File: rtl/calc_pkg.sv
// Shared types and operator codes for the RPN calculator front-end.
package calc_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_SUB = 5'b10100;
    localparam logic [4:0] OP_OR  = 5'b10010;
    localparam logic [4:0] OP_AND = 5'b10101;
    localparam logic [4:0] OP_MUL = 5'b10001;

    // True for the five operator codes the ALU implements.
    function automatic logic op_valid(input logic [4:0] code);
        logic ok;
        ok = 1'b0;
        case (code)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_MUL: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registers a level input and emits a one-cycle pulse on its rising edge.
// The register resets to 1 so a level already high at reset release does not fire.
module edge_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    // Rising edge: high now, low last cycle.
    always_comb begin
        rise = d & ~d_q;
    end

endmodule

// File: rtl/calc_rpn_ctrl.sv
// Sequential operand/operator capture for the shared lab-board ALU, with result
// hold and chaining of the result into operand A.
module calc_rpn_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] dato,
    input  logic             enter,
    input  logic             clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   operador,
    input  logic [WIDTH-1:0] resultado,
    output logic [WIDTH-1:0] display,
    output logic [2:0]       estado,
    output logic             res_valid,
    output logic             op_error
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             err_q, err_d;
    logic             ev;
    logic [OPW-1:0]   op_code;

    edge_rise u_enter_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (enter),
        .rise    (ev)
    );

    assign op_code = dato[OPW-1:0];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Next-state and register updates; clear overrides any enter event.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        err_d   = err_q;

        if (clear) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            res_d   = '0;
            op_d    = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_A: begin
                    if (ev) begin
                        a_d     = dato;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (ev) begin
                        b_d     = dato;
                        state_d = WAIT_OP;
                    end
                end
                WAIT_OP: begin
                    if (ev) begin
                        if (op_valid(op_code)) begin
                            op_d    = op_code;
                            err_d   = 1'b0;
                            state_d = EXEC;
                        end else begin
                            // Bad code: flag it, keep the last good operator.
                            err_d = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Operands have been stable for this whole cycle.
                    res_d   = resultado;
                    state_d = SHOW;
                end
                SHOW: begin
                    if (ev) begin
                        a_d     = res_q;
                        b_d     = '0;
                        state_d = WAIT_B;
                    end
                end
                default: state_d = WAIT_A;
            endcase
        end
    end

    // Output decode: show the switches while entering, the result afterwards.
    always_comb begin
        A         = a_q;
        B         = b_q;
        operador  = op_q;
        op_error  = err_q;
        estado    = state_q;
        res_valid = (state_q == SHOW);
        display   = ((state_q == EXEC) || (state_q == SHOW)) ? res_q : dato;
    end

endmodule

// File: tb/tb_calc_rpn_ctrl.sv
// Directed self-checking bench for calc_rpn_ctrl with a reference ALU attached.
module tb_calc_rpn_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 5;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] dato;
    logic             enter;
    logic             clear;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OPW-1:0]   operador;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] display;
    logic [2:0]       estado;
    logic             res_valid;
    logic             op_error;

    int checks;
    int errors;

    calc_rpn_ctrl #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dato      (dato),
        .enter     (enter),
        .clear     (clear),
        .A         (A),
        .B         (B),
        .operador  (operador),
        .resultado (resultado),
        .display   (display),
        .estado    (estado),
        .res_valid (res_valid),
        .op_error  (op_error)
    );

    // Reference ALU.
    always_comb begin
        case (operador)
            5'b10000: resultado = A + B;
            5'b10100: resultado = A - B;
            5'b10010: resultado = A | B;
            5'b10101: resultado = A & B;
            5'b10001: resultado = A * B;
            default:  resultado = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full button press: high for one edge, then low for one edge.
    task automatic press(input logic [WIDTH-1:0] v);
        dato  = v;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        dato    = 16'h1234;
        enter   = 1'b0;
        clear   = 1'b0;
        reset_n = 1'b0;
        #12;
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado got %0d want 0", estado); end
        checks++; if (A !== 16'h0 || B !== 16'h0) begin errors++; $display("FAIL reset_ab got %h/%h want 0/0", A, B); end
        checks++; if (operador !== 5'b00000 || op_error !== 1'b0) begin errors++; $display("FAIL reset_op got %b/%b want 00000/0", operador, op_error); end
        checks++; if (display !== 16'h1234 || res_valid !== 1'b0) begin errors++; $display("FAIL reset_disp got %h/%b want 1234/0", display, res_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_add_chain();
        press(16'h0005);
        checks++; if (A !== 16'h0005 || estado !== 3'd1) begin errors++; $display("FAIL add_capA got %h/%0d want 0005/1", A, estado); end
        press(16'h0003);
        checks++; if (B !== 16'h0003 || estado !== 3'd2) begin errors++; $display("FAIL add_capB got %h/%0d want 0003/2", B, estado); end
        dato  = 16'h0010;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++; if (estado !== 3'd3 || res_valid !== 1'b0) begin errors++; $display("FAIL add_exec got %0d/%b want 3/0", estado, res_valid); end
        checks++; if (operador !== 5'b10000) begin errors++; $display("FAIL add_op got %b want 10000", operador); end
        tick();
        checks++; if (display !== 16'h0008 || res_valid !== 1'b1 || estado !== 3'd4) begin errors++; $display("FAIL add_result got %h/%b/%0d want 0008/1/4", display, res_valid, estado); end
        // Chain: result becomes A, switch value is not used.
        press(16'h0002);
        checks++; if (A !== 16'h0008 || B !== 16'h0000 || estado !== 3'd1) begin errors++; $display("FAIL chain_cap got %h/%h/%0d want 0008/0000/1", A, B, estado); end
        press(16'h0002);
        press(16'h0014);
        checks++; if (display !== 16'h0006 || res_valid !== 1'b1) begin errors++; $display("FAIL chain_sub got %h/%b want 0006/1", display, res_valid); end
        do_clear();
        checks++; if (estado !== 3'd0 || A !== 16'h0 || operador !== 5'b0) begin errors++; $display("FAIL clear_show got %0d/%h/%b want 0/0000/00000", estado, A, operador); end
    endtask

    task automatic test_wrap_trunc();
        press(16'h0002);
        press(16'h0005);
        press(16'h0014);
        checks++; if (display !== 16'hFFFD) begin errors++; $display("FAIL sub_wrap got %h want fffd", display); end
        do_clear();
        press(16'h0100);
        press(16'h0100);
        press(16'h0011);
        checks++; if (display !== 16'h0000 || res_valid !== 1'b1) begin errors++; $display("FAIL mul_trunc got %h/%b want 0000/1", display, res_valid); end
        do_clear();
    endtask

    task automatic test_invalid_op();
        press(16'h00F0);
        press(16'h003C);
        press(16'h0007);
        checks++; if (op_error !== 1'b1 || estado !== 3'd2) begin errors++; $display("FAIL inv_err got %b/%0d want 1/2", op_error, estado); end
        checks++; if (operador !== 5'b00000) begin errors++; $display("FAIL inv_keep got %b want 00000", operador); end
        press(16'h0015);
        checks++; if (op_error !== 1'b0 || operador !== 5'b10101) begin errors++; $display("FAIL inv_recover got %b/%b want 0/10101", op_error, operador); end
        checks++; if (display !== 16'h0030 || estado !== 3'd4) begin errors++; $display("FAIL inv_and got %h/%0d want 0030/4", display, estado); end
        do_clear();
    endtask

    task automatic test_held_enter();
        dato  = 16'h0009;
        enter = 1'b1;
        tick();
        dato = 16'h00AA;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (estado !== 3'd1 || A !== 16'h0009 || B !== 16'h0000) begin errors++; $display("FAIL held got %0d/%h/%h want 1/0009/0000", estado, A, B); end
        enter = 1'b0;
        tick();
    endtask

    task automatic test_clear_enter();
        dato  = 16'h0077;
        enter = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enter = 1'b0;
        checks++; if (estado !== 3'd0 || A !== 16'h0 || B !== 16'h0) begin errors++; $display("FAIL clr_ev got %0d/%h/%h want 0/0000/0000", estado, A, B); end
        tick();
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL clr_ev_drop got %0d want 0", estado); end
    endtask

    task automatic test_reset_show();
        press(16'h0001);
        press(16'h0001);
        press(16'h0010);
        checks++; if (display !== 16'h0002 || res_valid !== 1'b1) begin errors++; $display("FAIL pre_rst got %h/%b want 0002/1", display, res_valid); end
        dato  = 16'h0055;
        enter = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (estado !== 3'd0 || res_valid !== 1'b0 || display !== 16'h0055) begin errors++; $display("FAIL rst_show got %0d/%b/%h want 0/0/0055", estado, res_valid, display); end
        checks++; if (A !== 16'h0 || B !== 16'h0 || operador !== 5'b0 || op_error !== 1'b0) begin errors++; $display("FAIL rst_regs got %h/%h/%b/%b want 0/0/0/0", A, B, operador, op_error); end
        @(negedge clk);
        reset_n = 1'b1;
        // Button still held across release: must not fire.
        tick();
        tick();
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL rst_held got %0d want 0", estado); end
        enter = 1'b0;
        tick();
        press(16'h0042);
        checks++; if (estado !== 3'd1 || A !== 16'h0042) begin errors++; $display("FAIL rst_after got %0d/%h want 1/0042", estado, A); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_chain();
        test_wrap_trunc();
        test_invalid_op();
        test_held_enter();
        test_clear_enter();
        test_reset_show();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
